// File: rtl/pc_gen.sv
// IF-stage fetch-address generator: reset vector, stall, branch and flush redirects.
// The pc, ce and misalignment flag are all registered and update together.
module pc_gen #(
    parameter int                 ADDR_W       = 32,
    parameter int                 INST_BYTES   = 4,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              pc_misalign
);

    // A mask of zero (INST_BYTES=1) makes the misalignment flag constant 0.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);

    typedef enum logic {OFF, RUN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q;
    logic              misalign_q;

    always_comb begin
        pc_d = pc_q + PC_INC;
        if (state_q == OFF)
            pc_d = RESET_VECTOR;
        else if (flush)
            pc_d = new_pc;
        else if (stall)
            pc_d = pc_q;
        else if (branch_flag)
            pc_d = branch_target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OFF;
            pc_q       <= RESET_VECTOR;
            ce_q       <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= RUN;
            pc_q       <= pc_d;
            ce_q       <= 1'b1;
            misalign_q <= |(pc_d & ALIGN_MASK);
        end
    end

    assign pc          = pc_q;
    assign ce          = ce_q;
    assign pc_misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural fetch-address model.
module tb_pc_gen;

    localparam logic [31:0] RV  = 32'hBFC0_0000;
    localparam logic [31:0] RV2 = 32'h0000_0101;

    logic        clk = 1'b0;
    logic        rst, stall, branch_flag, flush;
    logic [31:0] branch_target, new_pc;
    logic [31:0] pc, pc2;
    logic        ce, ce2, mis, mis2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .INST_BYTES(4), .RESET_VECTOR(RV)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
        .branch_target(branch_target), .flush(flush), .new_pc(new_pc),
        .pc(pc), .ce(ce), .pc_misalign(mis)
    );

    // Second instance: 2-byte fetch with an odd reset vector.
    pc_gen #(.ADDR_W(32), .INST_BYTES(2), .RESET_VECTOR(RV2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
        .branch_target(branch_target), .flush(flush), .new_pc(new_pc),
        .pc(pc2), .ce(ce2), .pc_misalign(mis2)
    );

    // Behavioural model of dut: running flag plus the fetch address it must show.
    logic        m_valid = 1'b0;
    logic        m_run;
    logic [31:0] m_pc;
    logic        m_mis;

    always @(posedge clk) begin
        logic [31:0] nxt;
        if (rst) begin
            m_valid <= 1'b1;
            m_run   <= 1'b0;
            m_pc    <= RV;
            m_mis   <= 1'b0;
        end else if (m_valid) begin
            if (!m_run) nxt = RV;
            else if (flush) nxt = new_pc;
            else if (stall) nxt = m_pc;
            else if (branch_flag) nxt = branch_target;
            else nxt = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            m_run <= 1'b1;
            m_pc  <= nxt;
            m_mis <= (nxt % 4) != 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc", pc, m_pc);
            chk("model_ce", 32'(ce), 32'(m_run));
            chk("model_mis", 32'(mis), 32'(m_mis));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; flush = 1'b0;
        branch_target = '0; new_pc = '0;
        #1;
        // Reset and release
        repeat (3) tick();
        chk("rst_pc", pc, RV);
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_mis", 32'(mis), 32'd0);
        rst = 1'b0;
        tick();
        chk("first_ce", 32'(ce), 32'd1);
        chk("first_pc", pc, 32'hBFC0_0000);
        chk("dut2_first_pc", pc2, 32'h0000_0101);
        chk("dut2_first_mis", 32'(mis2), 32'd1);
        tick();
        chk("seq_pc1", pc, 32'hBFC0_0004);
        chk("dut2_seq_pc", pc2, 32'h0000_0103);
        tick();
        chk("seq_pc2", pc, 32'hBFC0_0008);

        // Stall for 2 cycles at 0x100
        flush = 1'b1; new_pc = 32'h100;
        tick();
        chk("stall_pc0", pc, 32'h100);
        flush = 1'b0; stall = 1'b1;
        tick();
        chk("stall_pc1", pc, 32'h100);
        tick();
        chk("stall_pc2", pc, 32'h100);
        chk("stall_ce", 32'(ce), 32'd1);
        stall = 1'b0;
        tick();
        chk("stall_after", pc, 32'h104);

        // Branch, first masked by stall
        flush = 1'b1; new_pc = 32'h200;
        tick();
        flush = 1'b0; branch_flag = 1'b1; branch_target = 32'h80; stall = 1'b1;
        tick();
        chk("br_stalled", pc, 32'h200);
        stall = 1'b0;
        tick();
        chk("br_taken", pc, 32'h80);
        branch_flag = 1'b0;
        tick();
        chk("br_next", pc, 32'h84);

        // Flush beats stall and branch; misaligned flush target
        flush = 1'b1; new_pc = 32'h180; branch_flag = 1'b1; branch_target = 32'h40; stall = 1'b1;
        tick();
        chk("fl_pc", pc, 32'h180);
        chk("fl_mis", 32'(mis), 32'd0);
        new_pc = 32'h182;
        tick();
        chk("fl_mis_pc", pc, 32'h182);
        chk("fl_mis_flag", 32'(mis), 32'd1);
        flush = 1'b0; stall = 1'b0; branch_flag = 1'b0;
        tick();
        chk("mis_inc", pc, 32'h186);

        // Wrap at top of address space
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        tick();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_mis", 32'(mis), 32'd0);

        // Reset mid-run with branch pending
        rst = 1'b1; branch_flag = 1'b1; branch_target = 32'h500;
        tick();
        chk("mid_rst_pc", pc, RV);
        chk("mid_rst_ce", 32'(ce), 32'd0);
        rst = 1'b0; branch_flag = 1'b0;
        tick();
        chk("resume_pc", pc, RV);
        chk("resume_ce", 32'(ce), 32'd1);
        tick();
        chk("resume_pc1", pc, RV + 32'd4);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 63) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_flag   = ($urandom_range(0, 3) == 0);
            branch_target = $urandom() & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            new_pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                                        : $urandom();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
